sync_frame_tx: RTL and testbench
================================

Name: sync_frame_tx

Overview:
- Bit-serial frame transmitter: accepts a parallel word over a valid/ready handshake and emits a fixed sync pattern (default 1101), then the word, MSB first, one bit per clock on dout.
- Transmit-side counterpart of the team's 1101 sequence detectors; drives their din input in system use and in loopback benches.
- Sync insertion, frame length counting and back-to-back framing are all handled inside this block.

Parameters:
- DATA_W, 8, payload width in bits (2..32).
- SYNC_W, 4, sync pattern width in bits (1..8).
- SYNC_PATTERN, 4'b1101, sync bits, sent MSB first.
- IDLE_BIT, 1'b0, dout level when no frame is active.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  payload word; sampled only on an accepting edge.
- data_valid  input  1  payload word present on data_in.
- data_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit stream (registered).
- dout_valid  output  1  dout carries a frame bit this cycle (registered).
- busy  output  1  frame in progress (state is not IDLE).
- frame_done  output  1  one-cycle pulse coincident with the last frame bit on dout.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; shift register and bit counter cleared.
  - dout=IDLE_BIT, dout_valid=0, busy=0, frame_done=0.
  - data_ready=0 while reset_n is low.
- Frame length L = SYNC_W + DATA_W (+1 with the optional feature). Default L = 12.
- States:
  - IDLE: dout=IDLE_BIT, dout_valid=0.
  - SYNC: SYNC_W cycles emitting SYNC_PATTERN MSB first.
  - DATA: DATA_W cycles emitting the captured word MSB first.
  - PAR: present only with the optional feature; 1 cycle.
- Handshake:
  - A word is accepted on a rising edge where data_valid=1 and data_ready=1.
  - data_in is registered at that edge. Later changes to data_in have no effect on the frame in flight.
- data_ready (combinational from state):
  - 1 in IDLE.
  - 1 during the last bit cycle of a frame.
  - 0 otherwise.
- Latency: the first sync bit appears on dout with dout_valid=1 in the cycle after the accepting edge. Each bit is held exactly one cycle.
- Transitions:
  - IDLE -> SYNC on accept.
  - SYNC -> DATA after SYNC_W bits.
  - DATA -> PAR (feature on) or end-of-frame after DATA_W bits.
  - End of frame -> SYNC if a word was accepted on that edge (back-to-back, zero gap cycles); otherwise -> IDLE.
- frame_done is high exactly in the cycle the last bit of a frame is on dout, including in back-to-back operation.
- busy is high from the first sync bit through the last frame bit.
- data_valid held high while data_ready=0: nothing is captured and the frame in flight is unaffected. The word is taken at the next last-bit edge.
- Reset mid-frame: the frame is aborted immediately. dout returns to IDLE_BIT in the same cycle (asynchronous), and no frame_done is generated.
- Payload containing the sync pattern is not escaped; that is the receiver's responsibility.
- Bit counter width is clog2(L); the counter wraps to 0 at end of frame.

Optional Feature:
- Macro: SYNC_FRAME_TX_PARITY_EN.
- Defined:
  - PAR state appended after DATA, emitting an even-parity bit (XOR of the captured word).
  - L increases by 1. frame_done and data_ready move to the parity cycle.
- Undefined:
  - No PAR state and no parity logic.
  - The frame ends on data bit 0.

Test Plan:
- Reset, then data_in=8'hA5 with data_valid pulsed one cycle:
  - dout = 1,1,0,1,1,0,1,0,0,1,0,1 over the next 12 cycles, dout_valid=1 throughout.
  - frame_done high only in cycle 12, then IDLE with dout=0.
- Back-to-back 8'hA5 then 8'h3C (valid held):
  - 24 contiguous valid bits: 110110100101 followed by 110100111100.
  - Two frame_done pulses, 12 cycles apart; no idle cycle between frames.
- data_valid held high with data_in changed mid-frame from 8'hA5 to 8'hFF:
  - The first frame still carries A5.
  - The second frame carries FF.
  - data_ready is high only in IDLE and in last-bit cycles.
- reset_n asserted low in the 6th bit cycle of a frame:
  - dout=0, dout_valid=0, busy=0 immediately; no frame_done.
  - After release, a new 8'h0F frame transmits correctly.
- SYNC_FRAME_TX_PARITY_EN defined:
  - 8'hA5 yields 13 bits ending with parity 0.
  - 8'h07 ends with parity 1.
  - frame_done occurs on bit 13.
- Loopback into the 1101 Mealy detector with payload 8'h00:
  - Exactly one detection per frame, aligned to the final sync bit.

Source files
------------

// File: rtl/sync_frame_tx.sv
// Bit-serial frame transmitter: sync pattern then payload MSB first, back-to-back capable.
// Optional even-parity trailer bit enabled by defining SYNC_FRAME_TX_PARITY_EN.
module sync_frame_tx #(
   parameter int unsigned       DATA_W       = 8,
   parameter int unsigned       SYNC_W       = 4,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1101,
   parameter logic              IDLE_BIT     = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              dout,
   output logic              dout_valid,
   output logic              busy,
   output logic              frame_done
);

`ifdef SYNC_FRAME_TX_PARITY_EN
   localparam int unsigned PAR_W = 1;
`else
   localparam int unsigned PAR_W = 0;
`endif
   localparam int unsigned FRAME_W = SYNC_W + DATA_W + PAR_W;
   localparam int unsigned CNT_W   = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] DATA_IDX = CNT_W'(SYNC_W);
`ifdef SYNC_FRAME_TX_PARITY_EN
   localparam logic [CNT_W-1:0] PAR_IDX  = CNT_W'(SYNC_W + DATA_W);

   typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

   state_t               r_state, w_nxt_state;
   logic [CNT_W-1:0]     r_cnt, w_nxt_cnt, w_step_cnt;
   logic [FRAME_W-2:0]   r_shift, w_nxt_shift;
   logic                 r_dout, w_nxt_dout;
   logic                 r_dout_valid, w_nxt_valid;
   logic                 r_frame_done, w_nxt_done;
   logic [FRAME_W-1:0]   w_frame;
   logic                 w_last;
   logic                 w_accept;

`ifdef SYNC_FRAME_TX_PARITY_EN
   assign w_frame = {SYNC_PATTERN, data_in, ^data_in};
`else
   assign w_frame = {SYNC_PATTERN, data_in};
`endif

   assign w_last     = (r_state != IDLE) && (r_cnt == LAST_IDX);
   assign data_ready = reset_n && ((r_state == IDLE) || w_last);
   assign w_accept   = data_valid && data_ready;
   assign busy       = (r_state != IDLE);
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign frame_done = r_frame_done;

   // State register; r_dout always shows the bit indexed by r_cnt, r_shift holds the rest
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_dout       <= IDLE_BIT;
         r_dout_valid <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_cnt        <= w_nxt_cnt;
         r_shift      <= w_nxt_shift;
         r_dout       <= w_nxt_dout;
         r_dout_valid <= w_nxt_valid;
         r_frame_done <= w_nxt_done;
      end
   end

   // Next state and next registered outputs; an accept in the last bit cycle restarts at once
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_shift = r_shift;
      w_nxt_dout  = IDLE_BIT;
      w_nxt_valid = 1'b0;
      w_nxt_done  = 1'b0;
      w_step_cnt  = r_cnt + CNT_W'(1);

      if (w_accept) begin
         w_nxt_state = SYNC;
         w_nxt_cnt   = '0;
         w_nxt_shift = w_frame[FRAME_W-2:0];
         w_nxt_dout  = w_frame[FRAME_W-1];
         w_nxt_valid = 1'b1;
      end else if (w_last) begin
         w_nxt_state = IDLE;
         w_nxt_cnt   = '0;
         w_nxt_shift = '0;
      end else if (r_state != IDLE) begin
         w_nxt_cnt   = w_step_cnt;
         w_nxt_shift = {r_shift[FRAME_W-3:0], 1'b0};
         w_nxt_dout  = r_shift[FRAME_W-2];
         w_nxt_valid = 1'b1;
         w_nxt_done  = (w_step_cnt == LAST_IDX);
         if (w_step_cnt == DATA_IDX) begin
            w_nxt_state = DATA;
         end
`ifdef SYNC_FRAME_TX_PARITY_EN
         else if (w_step_cnt == PAR_IDX) begin
            w_nxt_state = PAR;
         end
`endif
      end
   end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Scoreboard bench for sync_frame_tx: a frame-level model queues expected bits, a monitor pops them.
module tb_sync_frame_tx;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned SYNC_W   = 4;
   localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1101;
   localparam logic        IDLE_BIT = 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
   localparam int unsigned FRAME_W  = SYNC_W + DATA_W + 1;
`else
   localparam int unsigned FRAME_W  = SYNC_W + DATA_W;
`endif

   typedef struct {
      logic b;
      logic last;
      logic sync_last;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic              data_ready;
   logic              dout;
   logic              dout_valid;
   logic              busy;
   logic              frame_done;

   exp_t  q[$];
   int    n_vec = 0;
   int    n_err = 0;
   bit    lb_mode = 1'b0;
   logic [3:0] hist = 4'b0000;

   always #5 clk = ~clk;

   sync_frame_tx dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .frame_done (frame_done)
   );

   // Reference: a frame is the sync pattern then the word MSB first (then even parity)
   task automatic push_frame(input logic [DATA_W-1:0] d);
      logic bits[FRAME_W];
      logic [SYNC_W-1:0] pat;
      pat = SYNC_PAT;
      for (int i = 0; i < int'(SYNC_W); i++) bits[i] = pat[SYNC_W-1-i];
      for (int i = 0; i < int'(DATA_W); i++) bits[SYNC_W+i] = d[DATA_W-1-i];
`ifdef SYNC_FRAME_TX_PARITY_EN
      bits[FRAME_W-1] = logic'($countones(d) % 2);
`endif
      for (int k = 0; k < int'(FRAME_W); k++)
         q.push_back('{b: bits[k], last: (k == int'(FRAME_W) - 1), sync_last: (k == int'(SYNC_W) - 1)});
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, output bit acc);
      @(negedge clk);
      data_valid = v;
      data_in    = d;
      #4;
      acc = v && data_ready && reset_n;
      if (acc) push_frame(d);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) drive(1'b0, $urandom, a);
   endtask

   task automatic send_until_taken(input logic [DATA_W-1:0] d);
      bit a;
      a = 1'b0;
      for (int i = 0; i < 40 && !a; i++) drive(1'b1, d, a);
      if (!a) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout: word %h not taken within 40 cycles", d);
      end
   endtask

   // Monitor: every cycle out of reset, compare outputs with the head of the expected queue
   logic [5:0] m_act, m_exp;
   exp_t       m_e;
   always @(negedge clk) begin
      if (reset_n) begin
         hist = {hist[2:0], dout};
         n_vec++;
         if (dout_valid) begin
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_bit: dout=%b with no frame pending", dout);
            end else begin
               m_e   = q.pop_front();
               m_act = {dout, frame_done, data_ready, busy, lb_mode ? (hist == 4'b1101) : 1'b0, dout_valid};
               m_exp = {m_e.b, m_e.last, m_e.last, 1'b1, lb_mode ? m_e.sync_last : 1'b0, 1'b1};
               if (m_act !== m_exp) begin
                  n_err++;
                  $display("FAIL frame_bit @%0t: {dout,done,ready,busy,det,valid} got %b expected %b", $time, m_act, m_exp);
               end
            end
         end else begin
            m_act = {dout, frame_done, data_ready, busy, 1'b0, q.size() != 0};
            m_exp = {IDLE_BIT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            if (m_act !== m_exp) begin
               n_err++;
               $display("FAIL idle_cycle @%0t: {dout,done,ready,busy,-,pending} got %b expected %b", $time, m_act, m_exp);
            end
         end
      end
   end

   initial begin
      bit a;
      reset_n    = 1'b0;
      data_valid = 1'b0;
      data_in    = '0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({dout, dout_valid, busy, frame_done, data_ready} !== {IDLE_BIT, 4'b0000}) begin
         n_err++;
         $display("FAIL reset_state: got %b expected %b", {dout, dout_valid, busy, frame_done, data_ready}, {IDLE_BIT, 4'b0000});
      end
      @(negedge clk);
      reset_n = 1'b1;

      // Single frame
      drive(1'b1, 8'hA5, a);
      idle(16);

      // Back-to-back frames with valid held
      send_until_taken(8'hA5);
      send_until_taken(8'h3C);
      idle(16);

      // Payload changed mid-frame while valid stays high
      send_until_taken(8'hA5);
      for (int i = 0; i < 3; i++) drive(1'b1, 8'hA5, a);
      send_until_taken(8'hFF);
      idle(16);

      // Reset in the 6th bit cycle of a frame
      send_until_taken(8'hA5);
      idle(5);
      #2;
      reset_n = 1'b0;
      q.delete();
      #1;
      n_vec++;
      if ({dout, dout_valid, busy, frame_done, data_ready} !== {IDLE_BIT, 4'b0000}) begin
         n_err++;
         $display("FAIL midframe_reset: got %b expected %b", {dout, dout_valid, busy, frame_done, data_ready}, {IDLE_BIT, 4'b0000});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      send_until_taken(8'h0F);
      idle(16);

      // Loopback-style check: one 1101 hit per zero-payload frame, on the last sync bit
      lb_mode = 1'b1;
      send_until_taken(8'h00);
      send_until_taken(8'h00);
      idle(16);
      lb_mode = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 400; i++) drive(logic'($urandom_range(0, 2) != 0), $urandom, a);

      // Drain with a bounded wait
      for (int i = 0; i < 40 && (q.size() != 0 || dout_valid); i++) idle(1);
      if (q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL drain_timeout: %0d bits still expected", q.size());
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
